// File: rtl/shutdown_sense_ctrl.sv
// Scan controller for the external 8:1 shutdown-sense mux: steps the select, settles, samples, latches sticky flags.
// Optional consecutive-sample filtering is enabled by defining SHUTDOWN_SENSE_FILTER_EN.
module shutdown_sense_ctrl #(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned FILTER_COUNT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              shutdown_sense_pin,
    output logic [SEL_W-1:0]  shutdown_sense_sel,
    output logic [NUM_CH-1:0] shutdown_sense,
    output logic [NUM_CH-1:0] shutdown_live,
    output logic              any_shutdown,
    output logic              scan_done,
    output logic              scanning
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    // Elaboration-time guard against configurations the scan timing cannot support
    if (SETTLE_CYCLES < 3 || FILTER_COUNT < 1 || NUM_CH < 2 || NUM_CH > (1 << SEL_W)) begin : g_bad_cfg
        $error("shutdown_sense_ctrl: unsupported parameter combination");
    end

    state_t            state;
    logic [CNT_W-1:0]  settle_cnt;
    logic [1:0]        sync_ff;
    logic              pin_s;
    logic              sample_now;
    logic [NUM_CH-1:0] set_mask;
    logic [NUM_CH-1:0] sense_nxt;

    assign pin_s      = sync_ff[1];
    assign sample_now = (state == SAMPLE);

`ifdef SHUTDOWN_SENSE_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_COUNT + 1);
    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILTER_COUNT);

    logic [FCNT_W-1:0] filt_cnt [NUM_CH];
    logic [FCNT_W-1:0] filt_nxt [NUM_CH];

    // Per-channel saturating run counters; a flag only sets on the FILTER_COUNT-th consecutive hit
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            filt_nxt[i] = clear ? '0 : filt_cnt[i];
            if (sample_now && shutdown_sense_sel == SEL_W'(i)) begin
                if (pin_s) begin
                    filt_nxt[i] = (filt_cnt[i] == FILT_MAX) ? FILT_MAX : filt_cnt[i] + FCNT_W'(1);
                    set_mask[i] = (filt_nxt[i] == FILT_MAX);
                end else begin
                    filt_nxt[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) filt_cnt[i] <= filt_nxt[i];
        end
    end
`else
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            set_mask[i] = sample_now && pin_s && (shutdown_sense_sel == SEL_W'(i));
        end
    end
`endif

    // A fault sampled in the same cycle as clear survives the clear
    assign sense_nxt = (clear ? '0 : shutdown_sense) | set_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            settle_cnt         <= '0;
            sync_ff            <= '0;
            shutdown_sense_sel <= '0;
            shutdown_sense     <= '0;
            shutdown_live      <= '0;
            any_shutdown       <= 1'b0;
            scan_done          <= 1'b0;
            scanning           <= 1'b0;
        end else begin
            sync_ff        <= {sync_ff[0], shutdown_sense_pin};
            shutdown_sense <= sense_nxt;
            any_shutdown   <= |shutdown_sense;
            scan_done      <= 1'b0;
            case (state)
                IDLE: begin
                    shutdown_sense_sel <= '0;
                    settle_cnt         <= '0;
                    if (enable) begin
                        state    <= SETTLE;
                        scanning <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        state              <= IDLE;
                        scanning           <= 1'b0;
                        shutdown_sense_sel <= '0;
                        settle_cnt         <= '0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (shutdown_sense_sel == SEL_W'(i)) shutdown_live[i] <= pin_s;
                    end
                    settle_cnt <= '0;
                    scan_done  <= (shutdown_sense_sel == SEL_LAST);
                    if (enable) begin
                        state              <= SETTLE;
                        shutdown_sense_sel <= (shutdown_sense_sel == SEL_LAST) ? '0
                                              : shutdown_sense_sel + SEL_W'(1);
                    end else begin
                        state              <= IDLE;
                        scanning           <= 1'b0;
                        shutdown_sense_sel <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    scanning <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shutdown_sense_ctrl.sv
// Directed self-checking bench for shutdown_sense_ctrl (default parameters, 17-cycle dwell, 136-cycle scan).
module tb_shutdown_sense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       pin;
    logic [2:0] sel;
    logic [7:0] sense;
    logic [7:0] live;
    logic       any_sd;
    logic       done;
    logic       scanning;

    int errors = 0;
    int checks = 0;

    shutdown_sense_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .clear              (clear),
        .shutdown_sense_pin (pin),
        .shutdown_sense_sel (sel),
        .shutdown_sense     (sense),
        .shutdown_live      (live),
        .any_shutdown       (any_sd),
        .scan_done          (done),
        .scanning           (scanning)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s @k=%0d: observed=%0h expected=%0h", tag, k, obs, exp_v);
        end
    endtask

    initial begin
        int exp_sel;
        int exp_sense;
        int exp_live;
        int sw;
        int m;

        rst = 1'b1; enable = 1'b0; clear = 1'b0; pin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 0, 32'(sel), 0);
        chk("rst_sense", 0, 32'(sense), 0);
        chk("rst_live", 0, 32'(live), 0);
        chk("rst_any", 0, 32'(any_sd), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_scanning", 0, 32'(scanning), 0);
        rst = 1'b0;

        // Idle with enable low: nothing moves
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            chk("idle_sel", k, 32'(sel), 0);
            chk("idle_scanning", k, 32'(scanning), 0);
            chk("idle_done", k, 32'(done), 0);
        end
        chk("idle_sense", 100, 32'(sense), 0);

`ifndef SHUTDOWN_SENSE_FILTER_EN
        // Sweep 0 clean, sweep 1 fault on ch5, sweep 2 fault on ch0, sweep 3 ch0 fault + clear, drop on ch3
        enable = 1'b1;
        for (int k = 1; k <= 480; k++) begin
            @(negedge clk);
            exp_sel   = (k >= 466) ? 0 : ((k - 1) / 17) % 8;
            exp_sense = (k < 239) ? 'h00 : (k < 290) ? 'h20 : (k < 426) ? 'h21 : 'h01;
            exp_live  = (k < 239) ? 'h00 : (k < 290) ? 'h20 : (k < 375) ? 'h21 : 'h01;
            chk("scan_sel", k, 32'(sel), 32'(exp_sel));
            chk("scan_done", k, 32'(done), (k == 137 || k == 273 || k == 409) ? 1 : 0);
            chk("scan_scanning", k, 32'(scanning), (k < 466) ? 1 : 0);
            chk("scan_sense", k, 32'(sense), 32'(exp_sense));
            chk("scan_live", k, 32'(live), 32'(exp_live));
            chk("scan_any", k, 32'(any_sd), (k >= 240) ? 1 : 0);
            if (k > 136 && k <= 272)      pin = (exp_sel == 5);
            else if (k > 272 && k <= 426) pin = (exp_sel == 0);
            else if (k > 426)             pin = (exp_sel == 3);
            else                          pin = 1'b0;
            clear  = (k == 425);
            enable = (k < 465);
        end

        // Re-enable restarts at channel 0
        pin = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("reen_sel", k, 32'(sel), 32'(((k - 1) / 17) % 8));
            chk("reen_scanning", k, 32'(scanning), 1);
            chk("reen_sense", k, 32'(sense), 'h01);
        end
`else
        // Ch2 asserted in sweeps 0,1,3,4,5 and low in sweep 2; flag needs three in a row
        enable = 1'b1;
        for (int k = 1; k <= 740; k++) begin
            @(negedge clk);
            exp_sel = ((k - 1) / 17) % 8;
            m = (k >= 52) ? (k - 52) / 136 : -1;
            exp_live = (m < 0 || m == 2) ? 'h00 : 'h04;
            chk("filt_sel", k, 32'(sel), 32'(exp_sel));
            chk("filt_done", k, 32'(done), (k > 1 && (k - 1) % 136 == 0) ? 1 : 0);
            chk("filt_sense", k, 32'(sense), (k >= 732) ? 'h04 : 'h00);
            chk("filt_live", k, 32'(live), 32'(exp_live));
            chk("filt_any", k, 32'(any_sd), (k >= 733) ? 1 : 0);
            sw  = (k - 1) / 136;
            pin = (exp_sel == 2) && (sw != 2) && (sw <= 5);
        end
`endif

        // Asynchronous reset in the middle of a cycle wipes everything at once
        pin = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_sense", 0, 32'(sense), 0);
        chk("arst_live", 0, 32'(live), 0);
        chk("arst_any", 0, 32'(any_sd), 0);
        chk("arst_sel", 0, 32'(sel), 0);
        chk("arst_scanning", 0, 32'(scanning), 0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; pin = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_sense", 5, 32'(sense), 0);
        chk("post_scanning", 5, 32'(scanning), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
